// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug UART: transmitter state encoding and frame geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dbg_pkg;

    // Transmitter states; IDLE is the only state in which the line is not carrying a frame.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // One start bit, eight data bits, one stop bit.
    localparam int FRAME_BITS     = 10;
    localparam int DATA_BITS      = FRAME_BITS - 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/dbg_uart_sync_fifo.sv
// Generic single-clock FIFO with registered pointers and a combinational head read.
// Latency: a word pushed at edge k is visible on dout_o after edge k.
// Backpressure: a push while full is written only if a pop happens on the same edge; otherwise it is ignored.
// Ports: clk/rst_n, push_i/din_i write side, pop_i read side, dout_o head word, full_o/empty_o status.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full (MSBs differ) from empty (MSBs equal).
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic wr_en;
    logic rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_en  = pop_i && !empty_o;
    // When full, the slot being written is the one being read out this edge, so a
    // simultaneous pop frees exactly the space the push needs.
    assign wr_en  = push_i && (!full_o || rd_en);
    assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/dbg_uart.sv
// Captures each change on the CPU debug bus into a FIFO and sends the words out LSB-byte-first as 8N1 UART.
// Latency: input change before edge k is queued at edge k, popped at k+1, start bit drives tx after k+1; 40*CLK_DIV cycles per word.
// Backpressure: none toward the CPU; a change arriving while the FIFO is full (and not popping) is dropped and counted.
// Ports: clk, rst_n (async active-low), dbg_in (CPU dbg_out), enable (capture gate),
//        tx (serial line, idle high), busy, overflow (sticky), drop_cnt (saturating at 255).
module dbg_uart
    import dbg_pkg::*;
#(
    parameter int CLK_DIV = 868,
    parameter int DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dbg_in,
    input  logic        enable,
    output logic        tx,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  drop_cnt
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);
    localparam logic [1:0]    BYTE_LAST = 2'(BYTES_PER_WORD - 1);

    // ---------------------------------------------------------------- change detect
    logic [31:0] prev_q;
    logic        push;

    assign push = enable && (dbg_in != prev_q);

    // ---------------------------------------------------------------- FIFO
    logic        pop;
    logic [31:0] fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (dbg_in),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ---------------------------------------------------------------- drop accounting
    logic       overflow_q;
    logic [7:0] drop_cnt_q;
    logic       drop;

    assign drop = push && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            prev_q <= dbg_in;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- transmitter
    tx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [1:0]    byte_q;
    logic [31:0]   word_q;
    logic          tx_q;

    logic bit_end;
    logic last_byte;

    assign bit_end   = (cnt_q == CNT_LAST);
    assign last_byte = (byte_q == BYTE_LAST);

    // Pop either to start from idle or to chain the next word straight after the final stop bit.
    assign pop = !fifo_empty &&
                 ((state_q == IDLE) ||
                  ((state_q == STOP) && bit_end && last_byte));

    // word_q shifts right one place per data bit, so word_q[0] is always the next bit to send
    // and after eight shifts the following byte sits in word_q[7:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    tx_q  <= 1'b1;
                    if (!fifo_empty) begin
                        word_q  <= fifo_dout;
                        byte_q  <= '0;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= word_q[0];
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q  <= '0;
                        word_q <= word_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= word_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (!last_byte) begin
                            byte_q  <= byte_q + 2'd1;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else if (!fifo_empty) begin
                            word_q  <= fifo_dout;
                            byte_q  <= '0;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = !fifo_empty || (state_q != IDLE);
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
